dec_scan_pol: RTL

//   Registered, parametrised N-to-2^N one-hot line decoder with selectable output polarity.

---
 rtl/dec_scan_pol.sv | 112 +++++++++++
 1 files changed

// File: rtl/dec_scan_pol.sv
// One-hot line decoder with two modes: direct select, or automatic scan with a programmable dwell time.
// d_out is registered, so it changes one cycle after a request is accepted or a scan step occurs.
// sel_ready is low during scan. en=0 always wins.
module dec_scan_pol #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8,
    parameter int SWAP01  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  pol,
    input  logic                  sel_valid,
    input  logic [SEL_W-1:0]      sel,
    output logic                  sel_ready,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(2**SEL_W)-1:0] d_out,
    output logic [SEL_W-1:0]      cur_idx,
    output logic                  wrap
);
    localparam int NL = 2**SEL_W;

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, SCAN = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [NL-1:0]      hot_q, hot_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               wrap_q, wrap_d;
    logic               pol_q, pol_d;
    logic               accept;

    function automatic logic [NL-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [NL-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Board wiring puts logical lines 0 and 1 on swapped pins.
    function automatic logic [NL-1:0] lane_map(input logic [NL-1:0] h);
        logic [NL-1:0] m;
        m = h;
        if (SWAP01 != 0) begin
            m[0] = h[1];
            m[1] = h[0];
        end
        return m;
    endfunction

    assign accept = sel_valid && sel_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hot_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            pol_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            hot_q   <= hot_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            pol_q   <= pol_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hot_d   = hot_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        pol_d   = pol;
        if (!en) begin
            state_d = IDLE;
            hot_d   = '0;
        end else if (mode && (state_q != SCAN)) begin
            // Scan entry always restarts at line 0, overriding any same-cycle request.
            state_d = SCAN;
            idx_d   = '0;
            hot_d   = onehot('0);
            cnt_d   = dwell;
        end else if (mode) begin
            if (cnt_q == '0) begin
                idx_d  = idx_q + SEL_W'(1);
                hot_d  = onehot(idx_d);
                cnt_d  = dwell;
                wrap_d = &idx_q;
            end else begin
                cnt_d = cnt_q - DWELL_W'(1);
            end
        end else if (state_q == SCAN) begin
            state_d = HOLD;
        end else if (accept) begin
            state_d = HOLD;
            idx_d   = sel;
            hot_d   = onehot(sel);
        end
    end

    always_comb begin
        sel_ready = (state_q != SCAN);
        d_out     = pol_q ? lane_map(hot_q) : ~lane_map(hot_q);
        cur_idx   = idx_q;
        wrap      = wrap_q;
    end
endmodule
